// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared opcode/state types and operand signedness helpers for muldiv_unit
package muldiv_pkg;
   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } muldiv_op_t;
   typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} muldiv_state_t;
   localparam int ITER_COUNT = 32;
   function automatic logic is_mul(input muldiv_op_t op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
   endfunction
   function automatic logic is_signed_a(input muldiv_op_t op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction
   function automatic logic is_signed_b(input muldiv_op_t op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: 64-bit accumulator with one shift-add multiply or restoring-divide step per cycle
module muldiv_datapath #(
   parameter int Data_Width = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic                      step,
   input  logic                      mode,
   input  logic [Data_Width-1:0]     abs_a,
   input  logic [Data_Width-1:0]     abs_b,
   output logic [2*Data_Width-1:0]   acc
);
   localparam int W = Data_Width;
   logic [W-1:0] b_q;
   logic [W:0]   sum, r_sh, diff;
   logic         ge;
   always_comb begin
      sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_q} : '0);
      r_sh = acc[2*W-1:W-1];
      diff = r_sh - {1'b0, b_q};
      ge   = r_sh >= {1'b0, b_q};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         b_q <= '0;
      end else if (load) begin
         acc <= {{W{1'b0}}, abs_a};
         b_q <= abs_b;
      end else if (step) begin
         acc <= mode ? {sum, acc[W-1:1]}
              : ge   ? {diff[W-1:0], acc[W-2:0], 1'b1}
              :        {r_sh[W-1:0], acc[W-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit; MULDIV_FAST_ZERO_EN enables the zero-operand shortcut
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int Data_Width    = 32,
   parameter int Address_Width = 5,
   parameter int Iter_Count    = ITER_COUNT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [2:0]               op,
   input  logic [Data_Width-1:0]    src_a,
   input  logic [Data_Width-1:0]    src_b,
   input  logic [Address_Width-1:0] rd_in,
   output logic                     busy,
   output logic                     done,
   output logic                     wr_en,
   output logic [Data_Width-1:0]    result,
   output logic [Address_Width-1:0] rd_out
);
   localparam int W = Data_Width;
   muldiv_state_t state, state_n;
   muldiv_op_t op_q;
   logic [W-1:0] a_q, b_q, abs_a, abs_b, fix_val, fast_val;
   logic [Address_Width-1:0] rd_q;
   logic [5:0] cnt;
   logic [2*W-1:0] acc, prod;
   logic sa, sb, neg_q, neg_r, fast;
   muldiv_datapath #(.Data_Width(W)) u_dp (
      .clk(clk),
      .rst(rst),
      .load(state == S_PREP),
      .step(state == S_CALC),
      .mode(is_mul(op_q)),
      .abs_a(abs_a),
      .abs_b(abs_b),
      .acc(acc)
   );
   always_comb begin
      sa       = is_signed_a(op_q) && a_q[W-1];
      sb       = is_signed_b(op_q) && b_q[W-1];
      abs_a    = sa ? -a_q : a_q;
      abs_b    = sb ? -b_q : b_q;
      prod     = neg_q ? -acc : acc;
      fix_val  = is_mul(op_q) ? (op_q == OP_MUL ? prod[W-1:0] : prod[2*W-1:W])
               : op_q inside {OP_DIV, OP_DIVU} ? (b_q == '0 ? '1 : neg_q ? -acc[W-1:0] : acc[W-1:0])
               : (neg_r ? -acc[2*W-1:W] : acc[2*W-1:W]);
      fast_val = is_mul(op_q) ? '0 : op_q inside {OP_DIV, OP_DIVU} ? '1 : a_q;
`ifdef MULDIV_FAST_ZERO_EN
      fast     = b_q == '0 || (is_mul(op_q) && a_q == '0);
`else
      fast     = 1'b0;
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  state_n = start ? S_PREP : S_IDLE;
         S_PREP:  state_n = fast ? S_DONE : S_CALC;
         S_CALC:  state_n = (cnt == 6'(Iter_Count - 1)) ? S_FIX : S_CALC;
         S_FIX:   state_n = S_DONE;
         default: state_n = S_IDLE;
      endcase
   end
   always_comb begin
      busy   = state != S_IDLE;
      done   = state == S_DONE;
      wr_en  = done && rd_q != '0;
      rd_out = rd_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= OP_MUL;
         a_q    <= '0;
         b_q    <= '0;
         rd_q   <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         result <= '0;
      end else begin
         if (state == S_IDLE && start) begin
            op_q <= muldiv_op_t'(op);
            a_q  <= src_a;
            b_q  <= src_b;
            rd_q <= rd_in;
         end
         if (state == S_PREP) begin
            cnt   <= '0;
            neg_q <= sa ^ sb;
            neg_r <= sa;
         end
         if (state == S_CALC) cnt <= cnt + 6'd1;
         if (state == S_PREP && fast) result <= fast_val;
         if (state == S_FIX) result <= fix_val;
      end
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting downstream of the register file read ports (operands `rd1`/`rd2`) and upstream of its write port (`din`/`en`/`rd`). It accepts one operation per start pulse, holds `busy` so control can stall the PC, and runs a 32-iteration shift-add multiplier or restoring divider. It then presents a registered result with a one-cycle write-back strobe.

## Interface
- `Data_Width`, 32: operand/result width; only 32 is supported.
- `Address_Width`, 5: destination register address width.
- `Iter_Count`, 32: iterations in CALC; equals `Data_Width`.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `src_a`  in  Data_Width  rs1 value (from `rd1`).
- `src_b`  in  Data_Width  rs2 value (from `rd2`).
- `rd_in`  in  Address_Width  destination register.
- `busy`  out  1  high from the capture edge until the edge ending DONE.
- `done`  out  1  one-cycle completion pulse.
- `wr_en`  out  1  write-back strobe to regfile `en`; equals `done && rd_out != 0`.
- `result`  out  Data_Width  to regfile `din`; held stable until the next capture.
- `rd_out`  out  Address_Width  to regfile `rd`; latched `rd_in`.

## Operation
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE: `start`=1 latches `op`, `src_a`, `src_b` and `rd_in`, then moves to PREP.
- PREP: takes operand absolute values according to signedness.
  - MULH: both operands signed.
  - MULHSU: `src_a` signed, `src_b` unsigned.
  - DIV and REM: both operands signed.
  - Records the result sign. Clears the 64-bit accumulator and the iteration counter. Moves to CALC.
- CALC: one iteration per cycle, with a 6-bit counter running 0..31. At count 31 moves to FIX.
  - Multiply: add-and-shift into a 64-bit product.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
- FIX: applies two's-complement negation where required, then selects the output.
  - Result selection: MUL → low word. MULH/MULHSU/MULHU → high word. DIV/DIVU → quotient. REM/REMU → remainder.
  - Registers `result` and moves to DONE.
- DONE: `done`=1 (and `wr_en` per rule) for exactly one cycle, then returns to IDLE.
- Sign rules: product sign = XOR of the signed operands' signs. Quotient sign = sign(a) XOR sign(b). Remainder takes the sign of the dividend.
- Divide by zero: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = `src_a`.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. This falls out of the unsigned 2^31/1 path plus negation; no special case is needed.
- `start` while not in IDLE is ignored; no queuing.
- `rd_in` = 0: the operation runs normally and `done` pulses, but `wr_en` stays 0.

## Timing
- Reset values: `busy`=0, `done`=0, `wr_en`=0, `result`=0, `rd_out`=0; state is IDLE.
- `rst` mid-operation aborts the operation in that edge: IDLE, outputs at reset values, no write-back.
- Edge-by-edge latency:
  - Edge E0 captures `start`.
  - E1 enters CALC.
  - E33 enters FIX.
  - E34 enters DONE.
  - `done`/`wr_en` are high in the cycle after E34.
  - E35 returns to IDLE; a new `start` can be captured at E36 at the earliest.
- `busy` rises in the cycle after E0 and falls in the cycle after E35.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_FAST_ZERO_EN` defined: PREP detects `src_b`==0 (any op) or `src_a`==0 (multiply ops).
  - On detection it loads the final result directly and jumps to DONE at E1; `done` is high in the cycle after E1.
- `MULDIV_FAST_ZERO_EN` undefined: all ops take the full 35-edge path; results are bit-identical either way.

## Structure
- Package `muldiv_pkg` holds:
  - `muldiv_op_t` enum, 3-bit, one member per funct3 value.
  - `muldiv_state_t` enum for the FSM states.
  - `ITER_COUNT` = 32.
  - Helper functions `is_mul(op)`, `is_signed_a(op)`, `is_signed_b(op)`.
- One sub-module, `muldiv_datapath`: the 64-bit accumulator, divisor/multiplicand registers and the per-iteration add/subtract-shift step.
  - Controlled by `load`/`step`/`mode` from the FSM in `muldiv_unit`.

## Test plan
- MUL 7 × −3, `rd_in`=5 → `result`=0xFFFFFFEB; `wr_en`=1 with `rd_out`=5 in the cycle after E34; `busy` high for 35 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7 / 2 → −3 (0xFFFFFFFD). REM −7 / 2 → −1. DIVU 7/0 → 0xFFFFFFFF. REMU 7/0 → 7.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Second `start` pulsed at E10 is ignored. `rst` asserted at E20 → outputs zero in the next cycle and no `wr_en`. `rd_in`=0 → `done` pulses with `wr_en`=0.
- With `MULDIV_FAST_ZERO_EN`: DIVU 5/0 → `done` in the cycle after E1 with `result`=0xFFFFFFFF. Without it, the same op → `done` in the cycle after E34.
